stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 tick_1hz  input  1: single-cycle count pulse, 1 Hz rate.
REQ-003 tick_2hz  input  1: single-cycle adjust/blink pulse, 2 Hz rate; never coincides with tick_1hz unless both are driven by the bench.
REQ-004 pause_btn  input  1: debounced level; each rising edge is one pause request.
REQ-005 clear_btn  input  1: debounced level; each rising edge is one clear request.
REQ-006 adj  input  1: level; high selects adjust mode.
REQ-007 sel  input  1: adjust target; 0 = minutes, 1 = seconds.
REQ-008 sec_carry  input  1: high while the seconds counter holds its MAX value (59).
REQ-009 sec_en  output  1: enable to the seconds counter.
REQ-010 min_en  output  1: enable to the minutes counter.
REQ-011 cnt_rst  output  1: synchronous reset to both counters.
REQ-012 blink  output  1: display blank phase for the selected field in adjust mode.
REQ-013 state  output  2: current FSM state code.

Function
REQ-014 The FSM SHALL have three states: RUN=2'd0, PAUSED=2'd1, ADJUST=2'd2; 2'd3 is illegal and SHALL decode to RUN on the next clk.
REQ-015 A pause edge is pause_btn=1 with the registered previous value 0; the same applies to clear edges.
REQ-016 On a pause edge, RUN SHALL go to PAUSED and PAUSED SHALL go to RUN; the change is visible at the next clk edge.
REQ-017 adj=1 SHALL move RUN or PAUSED to ADJUST at the next clk edge, and a 1-bit resume register SHALL store the state being left.
REQ-018 In ADJUST with adj=0, the FSM SHALL return to the stored resume state at the next clk edge.
REQ-019 In ADJUST, a pause edge SHALL toggle the resume register; state stays ADJUST.
REQ-020 If adj rises in the same cycle as a pause edge, the FSM SHALL toggle first and store the toggled value as resume, then enter ADJUST.
REQ-021 In RUN: sec_en = tick_1hz; min_en = tick_1hz & sec_carry (combinational, zero latency).
REQ-022 In PAUSED: sec_en = 0 and min_en = 0.
REQ-023 In ADJUST: sec_en = tick_2hz & sel and min_en = tick_2hz & ~sel; sec_carry SHALL be ignored.
REQ-024 A clear edge SHALL assert cnt_rst for exactly one cycle, registered, in the cycle after the edge; state and resume are unchanged.
REQ-025 While cnt_rst=1, sec_en and min_en SHALL be forced to 0, with cnt_rst overriding any coincident tick.
REQ-026 blink SHALL be a register toggled on every tick_2hz while in ADJUST.
REQ-027 blink SHALL be forced to 0 and the register cleared outside ADJUST.
REQ-028 Holding a button high SHALL produce only one request; a new request requires a low-then-high transition.

Reset
REQ-029 On rst=1 at a clk edge, the block SHALL set: state=RUN, resume=RUN, blink=0, both edge-detect history registers=0, cnt_rst=1.
REQ-030 sec_en and min_en SHALL be 0 while rst=1.
REQ-031 The cycle after rst deasserts, cnt_rst SHALL be 0 unless a clear edge occurred.
REQ-032 rst mid-ADJUST SHALL discard the resume value.
REQ-033 A button already high at reset release SHALL NOT generate an edge until it goes low and then high again.

Structure
REQ-034 State codes and the width constant SHALL live in shared package stopwatch_pkg, also used by the display mux.
REQ-035 Edge detection SHALL be one sub-module, rise_detect (clk, rst, d, pulse), instantiated twice.
REQ-036 The counters SHALL be external; this block contains no time-value registers.

Verification
REQ-037 Reset then RUN with 3 tick_1hz pulses, sec_carry=0 -> 3 sec_en pulses, min_en=0, state=0.
REQ-038 RUN, sec_carry=1 coincident with tick_1hz -> sec_en=1 and min_en=1 the same cycle.
REQ-039 Pause edge, then 2 ticks -> state=1, no enables; second pause edge -> state=0, next tick gives sec_en=1.
REQ-040 PAUSED, adj=1, sel=0, 2 tick_2hz, pause edge, adj=0 -> 2 min_en pulses, blink toggles 0->1->0, returns to RUN (state=0).
REQ-041 Clear edge coincident with tick_1hz+1 cycle -> cnt_rst=1 for one cycle, sec_en=0 that cycle, state unchanged.
REQ-042 pause_btn held high across rst release -> no state change until a low-then-high transition.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: state codes shared by the stopwatch controller and display mux
package stopwatch_pkg;
    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] RUN    = 2'd0;
    localparam logic [STATE_W-1:0] PAUSED = 2'd1;
    localparam logic [STATE_W-1:0] ADJUST = 2'd2;
endpackage

// File: rtl/rise_detect.sv
// rise_detect: one-cycle pulse on a low-to-high transition of a debounced level
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);
    logic prev;
    logic armed;
    // armed stays low until d is seen low, so a level held through reset is ignored
    assign pulse = d & ~prev & armed;
    always_ff @(posedge clk) begin
        prev  <= rst ? 1'b0 : d;
        armed <= rst ? 1'b0 : (armed | ~d);
    end
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/adjust control of external seconds/minutes counters
module stopwatch_ctrl
    import stopwatch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_1hz,
    input  logic               tick_2hz,
    input  logic               pause_btn,
    input  logic               clear_btn,
    input  logic               adj,
    input  logic               sel,
    input  logic               sec_carry,
    output logic               sec_en,
    output logic               min_en,
    output logic               cnt_rst,
    output logic               blink,
    output logic [STATE_W-1:0] state
);
    logic pause_p;
    logic clear_p;
    logic resume;
    logic blink_q;
    logic mode_nxt;
    logic adj_resume;
    logic [STATE_W-1:0] state_nxt;
    logic resume_nxt;

    rise_detect u_pause (.clk(clk), .rst(rst), .d(pause_btn), .pulse(pause_p));
    rise_detect u_clear (.clk(clk), .rst(rst), .d(clear_btn), .pulse(clear_p));

    // mode bit: 1 = paused; pause toggles before adj captures it
    always_comb begin
        mode_nxt   = (state == PAUSED) ^ pause_p;
        adj_resume = resume ^ pause_p;
        state_nxt  = RUN;
        resume_nxt = resume;
        if (state == RUN || state == PAUSED) begin
            state_nxt  = adj ? ADJUST : (mode_nxt ? PAUSED : RUN);
            resume_nxt = adj ? mode_nxt : resume;
        end else if (state == ADJUST) begin
            state_nxt  = adj ? ADJUST : (adj_resume ? PAUSED : RUN);
            resume_nxt = adj_resume;
        end
    end

    always_ff @(posedge clk) begin
        state   <= rst ? RUN : state_nxt;
        resume  <= rst ? 1'b0 : resume_nxt;
        cnt_rst <= rst | clear_p;
        blink_q <= (rst || state != ADJUST) ? 1'b0 : blink_q ^ tick_2hz;
    end

    always_comb begin
        sec_en = 1'b0;
        min_en = 1'b0;
        if (!rst && !cnt_rst) begin
            sec_en = (state == RUN) ? tick_1hz : (state == ADJUST) ? tick_2hz & sel : 1'b0;
            min_en = (state == RUN) ? tick_1hz & sec_carry : (state == ADJUST) ? tick_2hz & ~sel : 1'b0;
        end
    end

    assign blink = blink_q & (state == ADJUST);
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed checks of the stopwatch controller
module tb_stopwatch_ctrl;
    logic clk = 0;
    logic rst, tick_1hz, tick_2hz, pause_btn, clear_btn, adj, sel, sec_carry;
    logic sec_en, min_en, cnt_rst, blink;
    logic [1:0] state;
    int checks = 0;
    int failures = 0;

    stopwatch_ctrl dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
        .pause_btn(pause_btn), .clear_btn(clear_btn), .adj(adj), .sel(sel),
        .sec_carry(sec_carry), .sec_en(sec_en), .min_en(min_en),
        .cnt_rst(cnt_rst), .blink(blink), .state(state)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1; tick_1hz = 0; tick_2hz = 0; pause_btn = 0; clear_btn = 0;
        adj = 0; sel = 0; sec_carry = 0;
        cyc(); cyc();
        tick_1hz = 1; #1;
        chk("rst_state", state, 2'd0);
        chk("rst_cnt_rst", cnt_rst, 1);
        chk("rst_sec_en", sec_en, 0);
        chk("rst_blink", blink, 0);
        tick_1hz = 0; rst = 0;
        cyc();
        chk("post_rst_cnt_rst", cnt_rst, 0);

        for (int i = 0; i < 3; i++) begin
            tick_1hz = 1; #1;
            chk("run_sec_en", sec_en, 1);
            chk("run_min_en", min_en, 0);
            cyc(); tick_1hz = 0; cyc();
        end
        chk("run_state", state, 2'd0);

        sec_carry = 1; tick_1hz = 1; #1;
        chk("carry_sec_en", sec_en, 1);
        chk("carry_min_en", min_en, 1);
        cyc(); tick_1hz = 0; sec_carry = 0;

        pause_btn = 1; cyc(); pause_btn = 0;
        chk("pause_state", state, 2'd1);
        for (int i = 0; i < 2; i++) begin
            tick_1hz = 1; #1;
            chk("paused_sec_en", sec_en, 0);
            chk("paused_min_en", min_en, 0);
            cyc(); tick_1hz = 0; cyc();
        end
        pause_btn = 1; cyc(); pause_btn = 0;
        chk("unpause_state", state, 2'd0);
        tick_1hz = 1; #1;
        chk("unpause_sec_en", sec_en, 1);
        cyc(); tick_1hz = 0;

        pause_btn = 1; cyc(); cyc(); cyc();
        chk("hold_one_req", state, 2'd1);
        pause_btn = 0; cyc();

        adj = 1; sel = 0; sec_carry = 1; cyc();
        chk("adj_state", state, 2'd2);
        chk("adj_blink0", blink, 0);
        tick_2hz = 1; #1;
        chk("adj_min_en1", min_en, 1);
        chk("adj_sec_en1", sec_en, 0);
        cyc(); tick_2hz = 0;
        chk("adj_blink1", blink, 1);
        cyc();
        tick_2hz = 1; #1;
        chk("adj_min_en2", min_en, 1);
        cyc(); tick_2hz = 0;
        chk("adj_blink2", blink, 0);
        sel = 1; tick_2hz = 1; #1;
        chk("adj_sel_sec_en", sec_en, 1);
        chk("adj_sel_min_en", min_en, 0);
        cyc(); tick_2hz = 0; sec_carry = 0;
        chk("adj_blink3", blink, 1);
        pause_btn = 1; cyc(); pause_btn = 0;
        chk("adj_pause_stays", state, 2'd2);
        adj = 0; cyc();
        chk("adj_exit_run", state, 2'd0);
        chk("exit_blink", blink, 0);

        tick_1hz = 1; clear_btn = 1; #1;
        chk("clr_edge_sec_en", sec_en, 1);
        cyc(); #1;
        chk("clr_cnt_rst", cnt_rst, 1);
        chk("clr_sec_en_forced", sec_en, 0);
        chk("clr_state", state, 2'd0);
        cyc();
        chk("clr_one_cycle", cnt_rst, 0);
        clear_btn = 0; tick_1hz = 0; cyc();

        pause_btn = 1; adj = 1; cyc(); pause_btn = 0; adj = 0;
        chk("combo_adj", state, 2'd2);
        cyc();
        chk("combo_resume_paused", state, 2'd1);

        adj = 1; cyc();
        chk("adj_from_paused", state, 2'd2);
        rst = 1; cyc(); rst = 0;
        chk("rst_mid_adj", state, 2'd0);
        cyc(); adj = 0; cyc();
        chk("resume_discarded", state, 2'd0);

        pause_btn = 1; rst = 1; cyc(); cyc(); rst = 0; cyc(); cyc();
        chk("held_btn_no_edge", state, 2'd0);
        pause_btn = 0; cyc(); pause_btn = 1; cyc();
        chk("held_btn_new_edge", state, 2'd1);
        pause_btn = 0; cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
